// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART byte transmitter between four requesters.
// The winning byte is latched and the transmitter is enabled for one 10-bit frame, then an optional idle gap follows.
module uart_tx_arbiter #(
    parameter int unsigned BPS      = 434,
    parameter int unsigned GAP_CLKS = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [31:0] data_in,
    output logic [3:0]  ack,
    output logic        done,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        tx_en_sig,
    output logic [7:0]  tx_data
);

    localparam int unsigned FRAME = 10 * BPS;
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = (GAP_CLKS == 0) ? '0 : CNT_W'(GAP_CLKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       win;
    logic [1:0]       idx;

    // Winner is the first pending requester after the last grant; scanning
    // offsets high-to-low lets the nearest one overwrite the farther ones.
    always_comb begin
        win = grant;
        idx = '0;
        for (int o = 4; o >= 1; o--) begin
            idx = grant + 2'(o);
            if (req[idx]) begin
                win = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ack       <= '0;
            done      <= 1'b0;
            grant     <= 2'd3;
            busy      <= 1'b0;
            tx_en_sig <= 1'b0;
            tx_data   <= 8'h00;
        end else begin
            ack  <= '0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        tx_data   <= data_in[{win, 3'b000} +: 8];
                        grant     <= win;
                        ack       <= 4'b0001 << win;
                        tx_en_sig <= 1'b1;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (cnt == FRAME_LAST) begin
                        tx_en_sig <= 1'b0;
                        done      <= 1'b1;
                        cnt       <= '0;
                        if (GAP_CLKS == 0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: two instances (no gap / 5-clock gap) checked against a
// round-robin reference model and frame-timing arithmetic.
module tb_uart_tx_arbiter;

    localparam int FRAME = 40;
    localparam int GAP_B = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_v = '0;
    logic [31:0] data_v = '0;
    bit          sel = 1'b0;

    logic [3:0] req_a, req_b, ack_a, ack_b, ack_s;
    logic       done_a, done_b, done_s, busy_a, busy_b, busy_s, en_a, en_b, en_s;
    logic [1:0] grant_a, grant_b, grant_s;
    logic [7:0] txd_a, txd_b, txd_s;

    assign req_a   = sel ? 4'b0000 : req_v;
    assign req_b   = sel ? req_v : 4'b0000;
    assign ack_s   = sel ? ack_b : ack_a;
    assign done_s  = sel ? done_b : done_a;
    assign busy_s  = sel ? busy_b : busy_a;
    assign en_s    = sel ? en_b : en_a;
    assign grant_s = sel ? grant_b : grant_a;
    assign txd_s   = sel ? txd_b : txd_a;

    uart_tx_arbiter #(.BPS(4), .GAP_CLKS(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req_a), .data_in(data_v), .ack(ack_a), .done(done_a),
        .grant(grant_a), .busy(busy_a), .tx_en_sig(en_a), .tx_data(txd_a)
    );

    uart_tx_arbiter #(.BPS(4), .GAP_CLKS(GAP_B)) u_gap (
        .clk(clk), .rst_n(rst_n), .req(req_b), .data_in(data_v), .ack(ack_b), .done(done_b),
        .grant(grant_b), .busy(busy_b), .tx_en_sig(en_b), .tx_data(txd_b)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int model_last[2];
    int exp_g[$];
    int ack_g[$], ack_c[$], st_c[$], ln[$], dn_c[$], gapq[$];
    logic [7:0] ack_d[$];
    int bad_d, bad_oh, run, gb_cnt;
    bit en_prev, gb_act;
    logic [7:0] cur_d;

    task automatic clear_log();
        ack_g.delete(); ack_c.delete(); st_c.delete(); ln.delete();
        dn_c.delete(); gapq.delete(); ack_d.delete();
        bad_d = 0; bad_oh = 0;
    endtask

    // Reference arbitration: serve every pending requester, each time the nearest after the last served.
    function automatic void rr_plan(input logic [3:0] mask, input int s);
        logic [3:0] m = mask;
        exp_g.delete();
        while (m != 0) begin
            for (int o = 1; o <= 4; o++) begin
                int c = (model_last[s] + o) % 4;
                if (m[c]) begin
                    exp_g.push_back(c);
                    m[c] = 1'b0;
                    model_last[s] = c;
                    break;
                end
            end
        end
    endfunction

    // One clock: sample just after the edge, log events, and play the requesters' side of the handshake.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (ack_s != 4'b0000) begin
            if ($countones(ack_s) != 1) bad_oh++;
            for (int i = 0; i < 4; i++) begin
                if (ack_s[i]) begin
                    ack_g.push_back(i);
                    ack_c.push_back(cyc);
                    ack_d.push_back(txd_s);
                    cur_d = data_v[8*i +: 8];
                    req_v[i] = 1'b0;
                    data_v[8*i +: 8] = 8'($urandom);
                end
            end
        end
        if (en_s) begin
            if (!en_prev) begin
                st_c.push_back(cyc);
                run = 0;
            end
            run++;
            if (txd_s !== cur_d) bad_d++;
        end else if (en_prev) begin
            ln.push_back(run);
        end
        en_prev = en_s;
        if (done_s) begin
            dn_c.push_back(cyc);
            gb_act = 1'b1;
            gb_cnt = 0;
        end
        if (gb_act) begin
            if (busy_s) gb_cnt++;
            else begin
                gapq.push_back(gb_cnt);
                gb_act = 1'b0;
            end
        end
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(req_v == 4'b0000 && !busy_s && !en_s) && n < budget);
        n_tests++;
        if (!(req_v == 4'b0000 && !busy_s && !en_s)) begin
            n_fail++;
            $display("FAIL idle_timeout: still busy after %0d clocks, req=%b", n, req_v);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (en_a !== 1'b0)     begin n_fail++; $display("FAIL rst_tx_en: got %b want 0", en_a); end
        n_tests++; if (busy_a !== 1'b0)   begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy_a); end
        n_tests++; if (ack_a !== 4'b0000) begin n_fail++; $display("FAIL rst_ack: got %b want 0000", ack_a); end
        n_tests++; if (done_a !== 1'b0)   begin n_fail++; $display("FAIL rst_done: got %b want 0", done_a); end
        n_tests++; if (grant_a !== 2'd3)  begin n_fail++; $display("FAIL rst_grant: got %0d want 3", grant_a); end
        n_tests++; if (txd_a !== 8'h00)   begin n_fail++; $display("FAIL rst_tx_data: got %h want 00", txd_a); end
        n_tests++; if (grant_b !== 2'd3)  begin n_fail++; $display("FAIL rst_grant_gap: got %0d want 3", grant_b); end
        @(negedge clk);
        rst_n = 1'b1;
        model_last[0] = 3;
        model_last[1] = 3;
    endtask

    task automatic test_single();
        int g0, st0, dn0, gp0, ln0;
        sel = 1'b0;
        clear_log();
        data_v = $urandom;
        data_v[7:0] = 8'hA5;
        req_v = 4'b0001;
        run_idle(200);
        model_last[0] = 0;
        g0  = ack_g.size() > 0 ? ack_g[0] : -1;
        st0 = st_c.size() > 0 ? st_c[0] : -1;
        dn0 = dn_c.size() > 0 ? dn_c[0] : -1;
        gp0 = gapq.size() > 0 ? gapq[0] : -1;
        ln0 = ln.size() > 0 ? ln[0] : -1;
        n_tests++; if (ack_g.size() != 1) begin n_fail++; $display("FAIL single_ack_count: got %0d want 1", ack_g.size()); end
        n_tests++; if (g0 != 0) begin n_fail++; $display("FAIL single_grant: got %0d want 0", g0); end
        n_tests++; if (ack_d.size() == 0 || ack_d[0] !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", txd_a); end
        n_tests++; if (ln0 != FRAME) begin n_fail++; $display("FAIL single_len: got %0d want %0d", ln0, FRAME); end
        n_tests++; if (ack_c.size() == 0 || ack_c[0] != st0) begin n_fail++; $display("FAIL single_ack_vs_en: tx_en start %0d not ack cycle", st0); end
        n_tests++; if (dn0 != st0 + FRAME) begin n_fail++; $display("FAIL single_done_time: got %0d want %0d", dn0, st0 + FRAME); end
        n_tests++; if (gp0 != 0) begin n_fail++; $display("FAIL single_busy_after: busy held %0d clocks want 0", gp0); end
        n_tests++; if (bad_d != 0) begin n_fail++; $display("FAIL single_data_stable: %0d bad samples want 0", bad_d); end
    endtask

    // Serve one batch of simultaneous requests and compare against the model.
    task automatic test_batch(input logic [3:0] mask, input bit s, input string nm);
        logic [31:0] d;
        int gap;
        sel = s;
        clear_log();
        data_v = $urandom;
        d = data_v;
        gap = s ? GAP_B : 0;
        rr_plan(mask, 32'(s));
        req_v = mask;
        run_idle(1000);
        n_tests++;
        if (ack_g.size() != exp_g.size()) begin
            n_fail++; $display("FAIL %s_count: got %0d grants want %0d", nm, ack_g.size(), exp_g.size());
        end
        for (int i = 0; i < exp_g.size(); i++) begin
            int g  = i < ack_g.size() ? ack_g[i] : -1;
            int l  = i < ln.size() ? ln[i] : -1;
            int st = i < st_c.size() ? st_c[i] : -1;
            int dn = i < dn_c.size() ? dn_c[i] : -1;
            int gp = i < gapq.size() ? gapq[i] : -1;
            logic [7:0] dd = i < ack_d.size() ? ack_d[i] : 8'hxx;
            n_tests++; if (g != exp_g[i]) begin n_fail++; $display("FAIL %s_grant[%0d]: got %0d want %0d", nm, i, g, exp_g[i]); end
            n_tests++; if (dd !== d[8*exp_g[i] +: 8]) begin n_fail++; $display("FAIL %s_data[%0d]: got %h want %h", nm, i, dd, d[8*exp_g[i] +: 8]); end
            n_tests++; if (l != FRAME) begin n_fail++; $display("FAIL %s_len[%0d]: got %0d want %0d", nm, i, l, FRAME); end
            n_tests++; if (dn != st + FRAME) begin n_fail++; $display("FAIL %s_done[%0d]: got %0d want %0d", nm, i, dn, st + FRAME); end
            n_tests++; if (gp != gap) begin n_fail++; $display("FAIL %s_gap_busy[%0d]: got %0d want %0d", nm, i, gp, gap); end
            if (i > 0) begin
                int pst = i - 1 < st_c.size() ? st_c[i-1] : -1;
                n_tests++;
                if (st - pst != FRAME + 1 + gap) begin
                    n_fail++; $display("FAIL %s_period[%0d]: got %0d want %0d", nm, i, st - pst, FRAME + 1 + gap);
                end
            end
        end
        n_tests++; if (bad_d != 0) begin n_fail++; $display("FAIL %s_data_stable: %0d bad samples want 0", nm, bad_d); end
        n_tests++; if (bad_oh != 0) begin n_fail++; $display("FAIL %s_ack_onehot: %0d bad samples want 0", nm, bad_oh); end
    endtask

    task automatic test_round_robin();
        test_batch(4'b1111, 1'b0, "rr_all");
        n_tests++; if (dn_c.size() != 4) begin n_fail++; $display("FAIL rr_done_count: got %0d want 4", dn_c.size()); end
    endtask

    task automatic test_fairness();
        int g0, g1;
        test_batch(4'b0100, 1'b0, "serve2");
        test_batch(4'b1001, 1'b0, "fair");
        g0 = ack_g.size() > 0 ? ack_g[0] : -1;
        g1 = ack_g.size() > 1 ? ack_g[1] : -1;
        n_tests++; if (g0 != 3) begin n_fail++; $display("FAIL fair_first: got %0d want 3", g0); end
        n_tests++; if (g1 != 0) begin n_fail++; $display("FAIL fair_second: got %0d want 0", g1); end
    endtask

    task automatic test_gap();
        int lo;
        test_batch(4'b0011, 1'b1, "gap");
        lo = st_c.size() > 1 ? st_c[1] - (st_c[0] + FRAME) : -1;
        n_tests++; if (lo != GAP_B + 1) begin n_fail++; $display("FAIL gap_low_clocks: got %0d want %0d", lo, GAP_B + 1); end
        sel = 1'b0;
    endtask

    task automatic test_mid_reset();
        int n = 0;
        sel = 1'b0;
        clear_log();
        data_v = $urandom;
        req_v = 4'b0100;
        while (ack_g.size() == 0 && n < 10) begin step(); n++; end
        n_tests++; if (ack_g.size() == 0) begin n_fail++; $display("FAIL mrst_no_ack: got 0 acks want 1"); end
        repeat (16) step();
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (en_a !== 1'b0)     begin n_fail++; $display("FAIL mrst_tx_en: got %b want 0", en_a); end
        n_tests++; if (busy_a !== 1'b0)   begin n_fail++; $display("FAIL mrst_busy: got %b want 0", busy_a); end
        n_tests++; if (ack_a !== 4'b0000) begin n_fail++; $display("FAIL mrst_ack: got %b want 0000", ack_a); end
        n_tests++; if (done_a !== 1'b0)   begin n_fail++; $display("FAIL mrst_done: got %b want 0", done_a); end
        n_tests++; if (grant_a !== 2'd3)  begin n_fail++; $display("FAIL mrst_grant: got %0d want 3", grant_a); end
        req_v = 4'b0000;
        en_prev = 1'b0;
        gb_act = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_last[0] = 3;
        model_last[1] = 3;
        test_batch(4'b0010, 1'b0, "post_rst");
    endtask

    task automatic test_withdraw();
        int n = 0;
        int c1 = 0;
        sel = 1'b0;
        clear_log();
        data_v = $urandom;
        req_v = 4'b0001;
        while (ack_g.size() == 0 && n < 10) begin step(); n++; end
        repeat (5) step();
        req_v[1] = 1'b1;
        repeat (3) step();
        req_v[1] = 1'b0;
        req_v[2] = 1'b1;
        run_idle(500);
        model_last[0] = 2;
        foreach (ack_g[i]) if (ack_g[i] == 1) c1++;
        n_tests++; if (c1 != 0) begin n_fail++; $display("FAIL wd_served: requester 1 got %0d acks want 0", c1); end
        n_tests++; if (ack_g.size() != 2) begin n_fail++; $display("FAIL wd_count: got %0d grants want 2", ack_g.size()); end
        n_tests++; if (ack_g.size() < 2 || ack_g[1] != 2) begin n_fail++; $display("FAIL wd_next: second grant not 2 (count %0d)", ack_g.size()); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            bit s = 1'($urandom_range(0, 1));
            logic [3:0] mask = 4'($urandom_range(1, 15));
            test_batch(mask, s, "rand");
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_gap();
        test_mid_reset();
        test_withdraw();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "timeout");
    end

endmodule
